cache_mem_arbiter: RTL

//  Shares the single main-memory port between the icache refill path and the dcache refill/writeback path.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 31 +++
 rtl/cache_mem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state and owner encodings for cache_mem_arbiter
// Purpose: one place for the arbiter FSM encoding and the owner encoding
//          used by the round-robin grant logic and the top level.
// Ports:   none (package)
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } arb_state_t;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant between icache and dcache
// Purpose: pick a winner from the two request lines; on a tie the requester
//          that did not win last time is chosen.
// Ports:
//   req_ic      in  icache requesting
//   req_dc      in  dcache requesting
//   last_grant  in  owner of the previous grant (OWN_IC / OWN_DC)
//   grant_valid out at least one requester is asking
//   grant       out winning owner, meaningful only with grant_valid
module rr_arbiter2
    import arb_pkg::*;
(
    input  logic req_ic,
    input  logic req_dc,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        grant_valid = req_ic | req_dc;
        if (req_ic && req_dc) begin
            grant = ~last_grant;
        end else if (req_dc) begin
            grant = OWN_DC;
        end else begin
            grant = OWN_IC;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one main-memory port between icache and dcache refills
// Purpose: round-robin arbitration of icache line reads and dcache line
//          reads/writebacks onto a single memory port, one burst of BEATS
//          words in flight at a time.
// Ports:
//   clk, reset                          clock, async active-high reset
//   ic_req_valid/ready/addr             icache line-read request
//   dc_req_valid/ready/rw/addr          dcache line read (rw=0) or write (rw=1)
//   dc_wdata_valid/ready, dc_wdata      dcache write beats
//   ic_resp_valid, dc_resp_valid        read beat strobes to the owning cache
//   resp_data                           read beat data (mem_resp_data pass-through)
//   mem_req_valid/ready/rw/addr         memory request
//   mem_wdata_valid/ready, mem_wdata    memory write beats
//   mem_resp_valid, mem_resp_data       memory read beats, in order
module cache_mem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              ic_resp_valid,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t        state, state_n;
    logic              owner, last_grant, rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;
    logic              grant_valid, grant, grant_fire, beat;

    rr_arbiter2 u_rr (
        .req_ic      (ic_req_valid),
        .req_dc      (dc_req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // Grants only come out of IDLE, which the FSM always spends at least one
    // cycle in after a burst. Gating with reset keeps readys low while the
    // async reset is held even though state is already IDLE.
    assign grant_fire = (state == IDLE) && grant_valid && !reset;

    always_comb begin
        state_n = state;
        beat    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_fire) state_n = REQ;
            end
            REQ: begin
                if (mem_req_ready) state_n = rw_q ? WDATA : RDATA;
            end
            WDATA: begin
                beat = dc_wdata_valid && mem_wdata_ready;
                if (beat && cnt == LAST_BEAT) state_n = IDLE;
            end
            RDATA: begin
                beat = mem_resp_valid;
                if (beat && cnt == LAST_BEAT) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state == REQ && mem_req_ready) begin
                cnt <= '0;
            end else if (beat) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Request capture: loaded only on a grant so addr/rw stay stable through
    // REQ no matter what the caches do with their request lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= OWN_DC;
            last_grant <= OWN_IC;
            addr_q     <= '0;
            rw_q       <= 1'b0;
        end else if (grant_fire) begin
            owner      <= grant;
            last_grant <= grant;
            addr_q     <= (grant == OWN_DC) ? dc_req_addr : ic_req_addr;
            rw_q       <= (grant == OWN_DC) && dc_req_rw;
        end
    end

    assign ic_req_ready    = grant_fire && (grant == OWN_IC);
    assign dc_req_ready    = grant_fire && (grant == OWN_DC);

    assign mem_req_valid   = (state == REQ);
    assign mem_req_rw      = rw_q;
    assign mem_req_addr    = addr_q;

    assign mem_wdata_valid = (state == WDATA) && dc_wdata_valid;
    assign dc_wdata_ready  = (state == WDATA) && mem_wdata_ready;
    assign mem_wdata       = dc_wdata;

    // Memory beats only reach a cache while a read burst it owns is active.
    assign ic_resp_valid   = (state == RDATA) && mem_resp_valid && (owner == OWN_IC);
    assign dc_resp_valid   = (state == RDATA) && mem_resp_valid && (owner == OWN_DC);
    assign resp_data       = mem_resp_data;

endmodule
